// File: rtl/ps2_scan_receiver.sv
// rtl/ps2_scan_receiver.sv - PS/2 keyboard deframer assembling E0/F0-prefixed scan codes into a 24-bit key code
// Optional frame timeout enabled by defining ARILLA_PS2_TIMEOUT_EN.
module ps2_scan_receiver #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TO_W           = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PS2_CLK,
    input  logic        PS2_DATA,
    input  logic [4:0]  DEB_TIME,
    input  logic        SYNCH_EN,
    output logic [23:0] K_CD,
    output logic        CODE_VALID,
    output logic        F_ERR,
    output logic        P_ERR
);

    if ((2 ** TO_W) <= TIMEOUT_CYCLES) begin : g_bad_to_w
        $error("TO_W too narrow for TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Index 1 = PS2_CLK, index 0 = PS2_DATA throughout the input stage.
    logic [1:0] sync1_q, sync2_q, samp, filt_q, filt;
    logic [4:0] deb_cnt_q [2];
    logic       synch_en_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            synch_en_q <= 1'b0;
        end else begin
            sync1_q    <= {PS2_CLK, PS2_DATA};
            sync2_q    <= sync1_q;
            synch_en_q <= SYNCH_EN;
        end
    end

    assign samp = synch_en_q ? sync2_q : {PS2_CLK, PS2_DATA};

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                filt_q[i]    <= 1'b1;
                deb_cnt_q[i] <= 5'd0;
            end else if (DEB_TIME == 5'd0 || samp[i] == filt_q[i]) begin
                filt_q[i]    <= samp[i];
                deb_cnt_q[i] <= 5'd0;
            end else if (deb_cnt_q[i] + 5'd1 >= DEB_TIME) begin
                filt_q[i]    <= samp[i];
                deb_cnt_q[i] <= 5'd0;
            end else begin
                deb_cnt_q[i] <= deb_cnt_q[i] + 5'd1;
            end
        end
    end

    assign filt = (DEB_TIME == 5'd0) ? samp : filt_q;

    logic prev_clk_q, edge_q, bit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_clk_q <= 1'b1;
            edge_q     <= 1'b0;
            bit_q      <= 1'b1;
        end else begin
            prev_clk_q <= filt[1];
            edge_q     <= prev_clk_q & ~filt[1];
            bit_q      <= filt[0];
        end
    end

    state_t      state_q, state_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        par_q, par_d;
    logic [15:0] accum_q, accum_d;
    logic [23:0] kcd_d;
    logic        valid_d, ferr_d, perr_d;
    logic        timeout_hit;
    logic        par_bad;

`ifdef ARILLA_PS2_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || state_q == IDLE || edge_q)
            to_cnt_q <= '0;
        else
            to_cnt_q <= to_cnt_q + 1'b1;
    end

    assign timeout_hit = (state_q != IDLE) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Odd parity: data plus parity bit must hold an odd number of ones.
    assign par_bad = ~^{shreg_q, par_q};

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        accum_d  = accum_q;
        kcd_d    = K_CD;
        valid_d  = 1'b0;
        ferr_d   = F_ERR;
        perr_d   = P_ERR;
        if (edge_q) begin
            case (state_q)
                IDLE: begin
                    if (!bit_q) begin
                        state_d  = DATA;
                        bitcnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shreg_d  = {bit_q, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7)
                        state_d = PARITY;
                end
                PARITY: begin
                    par_d   = bit_q;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (par_bad || !bit_q) begin
                        if (par_bad)
                            perr_d = 1'b1;
                        if (!bit_q)
                            ferr_d = 1'b1;
                        accum_d = 16'd0;
                    end else begin
                        ferr_d = 1'b0;
                        perr_d = 1'b0;
                        if (shreg_q == 8'hE0 || shreg_q == 8'hF0) begin
                            accum_d = {accum_q[7:0], shreg_q};
                        end else begin
                            kcd_d   = {accum_q, shreg_q};
                            accum_d = 16'd0;
                            valid_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (timeout_hit) begin
            state_d = IDLE;
            ferr_d  = 1'b1;
            accum_d = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bitcnt_q   <= 3'd0;
            shreg_q    <= 8'd0;
            par_q      <= 1'b0;
            accum_q    <= 16'd0;
            K_CD       <= 24'd0;
            CODE_VALID <= 1'b0;
            F_ERR      <= 1'b0;
            P_ERR      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            accum_q    <= accum_d;
            K_CD       <= kcd_d;
            CODE_VALID <= valid_d;
            F_ERR      <= ferr_d;
            P_ERR      <= perr_d;
        end
    end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// tb/tb_ps2_scan_receiver.sv - randomized scoreboard bench for ps2_scan_receiver
module tb_ps2_scan_receiver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [4:0]  deb_time = 5'd3;
    logic        synch_en = 1'b1;
    logic [23:0] k_cd;
    logic        code_valid, f_err, p_err;

    int total = 0;
    int bad = 0;

    logic [23:0] exp_q[$];
    logic [7:0]  pfx[$];
    logic [23:0] e_kcd = 24'd0;
    logic        e_ferr = 1'b0;
    logic        e_perr = 1'b0;

    ps2_scan_receiver #(.TIMEOUT_CYCLES(100), .TO_W(16)) dut (
        .clk(clk), .rst(rst), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
        .DEB_TIME(deb_time), .SYNCH_EN(synch_en), .K_CD(k_cd),
        .CODE_VALID(code_valid), .F_ERR(f_err), .P_ERR(p_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Each CODE_VALID pulse must match the oldest outstanding expected code.
    always @(negedge clk) begin
        if (!rst && code_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid: got K_CD=%h expected no pulse", k_cd);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                if (k_cd !== e) begin
                    bad++;
                    $display("FAIL code_value: got %h expected %h", k_cd, e);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] build(input logic [7:0] b, input bit bp, input bit bs);
        logic par;
        par = ~(^b) ^ bp;
        return {~bs, par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            cycles(10);
            ps2_clk = 1'b0;
            cycles(20);
            ps2_clk = 1'b1;
            cycles(10);
        end
        ps2_data = 1'b1;
    endtask

    // Reference: prefixes kept as a byte list, errors wipe it, a code byte flushes it.
    task automatic model(input logic [7:0] b, input bit bp, input bit bs);
        if (bp || bs) begin
            if (bp) e_perr = 1'b1;
            if (bs) e_ferr = 1'b1;
            pfx.delete();
        end else begin
            e_perr = 1'b0;
            e_ferr = 1'b0;
            if (b == 8'hE0 || b == 8'hF0) begin
                pfx.push_back(b);
                if (pfx.size() > 2) void'(pfx.pop_front());
            end else begin
                e_kcd = {16'd0, b};
                for (int i = 0; i < pfx.size(); i++)
                    e_kcd = e_kcd + (24'(pfx[i]) << (8 * (pfx.size() - i)));
                exp_q.push_back(e_kcd);
                pfx.delete();
            end
        end
    endtask

    task automatic frame(input logic [7:0] b, input bit bp, input bit bs);
        model(b, bp, bs);
        send_bits(build(b, bp, bs), 11);
        cycles(10);
        chk("f_err", {31'd0, f_err}, {31'd0, e_ferr});
        chk("p_err", {31'd0, p_err}, {31'd0, e_perr});
        chk("k_cd_hold", {8'd0, k_cd}, {8'd0, e_kcd});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        cycles(4);
        chk("rst_k_cd", {8'd0, k_cd}, 32'd0);
        chk("rst_valid", {31'd0, code_valid}, 32'd0);
        chk("rst_f_err", {31'd0, f_err}, 32'd0);
        chk("rst_p_err", {31'd0, p_err}, 32'd0);
        pfx.delete();
        e_kcd = 24'd0;
        e_ferr = 1'b0;
        e_perr = 1'b0;
        rst = 1'b0;
        cycles(4);
    endtask

    initial begin
        logic [7:0] b;
        int r;
        cycles(1);
        do_reset();

        frame(8'h1C, 0, 0);
        frame(8'hE0, 0, 0);
        frame(8'hF0, 0, 0);
        frame(8'h75, 0, 0);
        frame(8'h1C, 0, 0);
        frame(8'h1C, 1, 0);
        frame(8'h29, 0, 0);
        frame(8'h1C, 0, 1);

        // Two-cycle low glitch on the clock line must not start a frame.
        ps2_data = 1'b0;
        cycles(5);
        ps2_clk = 1'b0;
        cycles(2);
        ps2_clk = 1'b1;
        cycles(5);
        ps2_data = 1'b1;
        cycles(20);
        frame(8'h5A, 0, 0);

        // Prefix overflow: the oldest prefix is dropped.
        frame(8'hF0, 0, 0);
        frame(8'hE0, 0, 0);
        frame(8'hF0, 0, 0);
        frame(8'h12, 0, 0);

`ifdef ARILLA_PS2_TIMEOUT_EN
        frame(8'hE0, 0, 0);
        send_bits(build(8'h33, 0, 0), 5);
        cycles(120);
        e_ferr = 1'b1;
        pfx.delete();
        chk("timeout_f_err", {31'd0, f_err}, 32'd1);
        frame(8'h1C, 0, 0);
`endif

        // Reset in the middle of an E0 frame drops the prefix.
        send_bits(build(8'hE0, 0, 0), 6);
        do_reset();
        frame(8'h75, 0, 0);

        for (int n = 0; n < 45; n++) begin
            synch_en = 1'($urandom_range(0, 1));
            deb_time = 5'($urandom_range(0, 6));
            cycles(3);
            r = $urandom_range(0, 9);
            b = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom_range(0, 255));
            frame(b, $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 8);
        end

        cycles(20);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
